// File: rtl/conv_pkg.sv
// Shared definitions for the layer-1/layer-2 max-pool + flatten stage.
// Holds the data width, memory-select codes of the shared memory port and
// the pooling FSM state encoding.
package conv_pkg;
  localparam int DW = 20;

  typedef enum logic [2:0] {
    CSEL_NONE  = 3'b000,
    CSEL_L0_M0 = 3'b001,
    CSEL_L0_M1 = 3'b010,
    CSEL_L1_M0 = 3'b011,
    CSEL_L1_M1 = 3'b100,
    CSEL_L2    = 3'b101
  } csel_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAST = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    DONE = 3'd5
  } state_e;
endpackage

// File: rtl/maxpool_addr_gen.sv
// Loop counters and address generation for the pooling stage.
// Ports:
//   clk, reset      clock, async active-low reset
//   i_clr           clear all counters (held while the FSM is idle)
//   i_k_inc         step the 2x2 window index k
//   i_adv           advance to the next output pixel (px, then py, then ch)
//   o_k, o_ch       current window index / channel
//   o_ch_nxt        channel value after this edge
//   o_last_px       current pixel is the final one (ch=1, py=31, px=31)
//   o_rd_addr_nxt   L0 read address for the counter values after this edge
//   o_l1_addr       L1 write address {py, px}
//   o_l2_addr       L2 write address {py, px, ch}
module maxpool_addr_gen
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_k_inc,
  input  logic        i_adv,
  output logic [1:0]  o_k,
  output logic        o_ch,
  output logic        o_ch_nxt,
  output logic        o_last_px,
  output logic [11:0] o_rd_addr_nxt,
  output logic [9:0]  o_l1_addr,
  output logic [10:0] o_l2_addr
);
  logic       r_ch, w_ch_nxt;
  logic [4:0] r_py, r_px, w_py_nxt, w_px_nxt;
  logic [1:0] r_k, w_k_nxt;

  always_comb begin
    w_k_nxt  = r_k;
    w_px_nxt = r_px;
    w_py_nxt = r_py;
    w_ch_nxt = r_ch;
    if (i_clr) begin
      w_k_nxt  = '0;
      w_px_nxt = '0;
      w_py_nxt = '0;
      w_ch_nxt = 1'b0;
    end else if (i_k_inc) begin
      w_k_nxt = r_k + 2'd1;
    end else if (i_adv) begin
      w_k_nxt  = '0;
      w_px_nxt = r_px + 5'd1;
      if (r_px == 5'd31) begin
        w_py_nxt = r_py + 5'd1;
        if (r_py == 5'd31) w_ch_nxt = ~r_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k  <= '0;
      r_px <= '0;
      r_py <= '0;
      r_ch <= 1'b0;
    end else begin
      r_k  <= w_k_nxt;
      r_px <= w_px_nxt;
      r_py <= w_py_nxt;
      r_ch <= w_ch_nxt;
    end
  end

  // Read address is built from the post-edge counters so the top can
  // register it in the same edge that enters the RD cycle it belongs to.
  // Row = 2*py + k[1], col = 2*px + k[0].
  assign o_rd_addr_nxt = {w_py_nxt, w_k_nxt[1], w_px_nxt, w_k_nxt[0]};
  assign o_l1_addr     = {r_py, r_px};
  assign o_l2_addr     = {r_py, r_px, r_ch};
  assign o_k           = r_k;
  assign o_ch          = r_ch;
  assign o_ch_nxt      = w_ch_nxt;
  assign o_last_px     = r_ch & (&r_py) & (&r_px);
endmodule

// File: rtl/maxpool_flatten.sv
// ReLU + 2x2/stride-2 max-pool over two 64x64 layer-0 maps, writing the
// 32x32 pooled maps to L1_MEM0/1 and the channel-interleaved flattened
// vector to L2_MEM. 7 cycles per output pixel: RD x4, LAST, WR1, WR2.
// Ports:
//   clk, reset   clock, async active-low reset
//   start        one-cycle request, honoured only while idle
//   busy, done   run in progress / one-cycle completion pulse
//   crd, caddr_rd, cdata_rd   memory read (data 1 cycle after request)
//   cwr, caddr_wr, cdata_wr   memory write
//   csel         memory select (conv_pkg::csel_e)
module maxpool_flatten
  import conv_pkg::*;
#(
  parameter int DW      = conv_pkg::DW,
  parameter int RELU_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [11:0]   caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [11:0]   caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);
  state_e        r_state, w_state_nxt;
  logic          r_go;
  logic [1:0]    w_k;
  logic          w_ch, w_ch_nxt, w_last;
  logic [11:0]   w_rd_addr_nxt;
  logic [9:0]    w_l1_addr;
  logic [10:0]   w_l2_addr;
  logic [DW-1:0] w_samp, w_max_nxt, r_max;
  logic          w_cap, w_first;
  csel_e         w_csel_nxt, r_csel;
  logic          r_busy, r_done, r_crd, r_cwr;
  logic [11:0]   r_caddr_rd, r_caddr_wr;
  logic [DW-1:0] r_cdata_wr;

  maxpool_addr_gen u_addr (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (r_state == IDLE),
    .i_k_inc      (r_state == RD),
    .i_adv        ((r_state == WR2) && !w_last),
    .o_k          (w_k),
    .o_ch         (w_ch),
    .o_ch_nxt     (w_ch_nxt),
    .o_last_px    (w_last),
    .o_rd_addr_nxt(w_rd_addr_nxt),
    .o_l1_addr    (w_l1_addr),
    .o_l2_addr    (w_l2_addr)
  );

  // Start is latched first and the FSM leaves IDLE on the following edge;
  // every bus output is then registered from the next-state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_go    <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_go    <= (r_state == IDLE) && start;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_go) w_state_nxt = RD;
      RD:      if (w_k == 2'd3) w_state_nxt = LAST;
      LAST:    w_state_nxt = WR1;
      WR1:     w_state_nxt = WR2;
      WR2:     w_state_nxt = w_last ? DONE : RD;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample requested in RD[k] arrives during RD[k+1] (or LAST for k=3).
  assign w_samp    = ((RELU_EN != 0) && cdata_rd[DW-1]) ? '0 : cdata_rd;
  assign w_cap     = ((r_state == RD) && (w_k != 2'd0)) || (r_state == LAST);
  assign w_first   = (r_state == RD) && (w_k == 2'd1);
  assign w_max_nxt = (w_first || ($signed(w_samp) > $signed(r_max))) ? w_samp : r_max;

  always_comb begin
    w_csel_nxt = CSEL_NONE;
    case (w_state_nxt)
      RD:      w_csel_nxt = w_ch_nxt ? CSEL_L0_M1 : CSEL_L0_M0;
      WR1:     w_csel_nxt = w_ch ? CSEL_L1_M1 : CSEL_L1_M0;
      WR2:     w_csel_nxt = CSEL_L2;
      default: w_csel_nxt = CSEL_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_csel     <= CSEL_NONE;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
    end else begin
      if (w_cap) r_max <= w_max_nxt;
      // LAST holds the final sample; the finished max goes straight to the bus
      if (r_state == LAST) r_cdata_wr <= w_max_nxt;
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
      r_crd  <= (w_state_nxt == RD);
      r_cwr  <= (w_state_nxt == WR1) || (w_state_nxt == WR2);
      r_csel <= w_csel_nxt;
      if (w_state_nxt == RD)  r_caddr_rd <= w_rd_addr_nxt;
      if (w_state_nxt == WR1) r_caddr_wr <= {2'b00, w_l1_addr};
      if (w_state_nxt == WR2) r_caddr_wr <= {1'b0, w_l2_addr};
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd;
  assign cwr      = r_cwr;
  assign csel     = r_csel;
  assign caddr_rd = r_caddr_rd;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;
endmodule

// File: tb/tb_maxpool_flatten.sv
// Bench for maxpool_flatten: two instances (ReLU on / off) share the L0
// maps; a pooling model builds the expected write stream per instance.
module tb_maxpool_flatten;
  localparam int DW = 20;
  typedef struct packed {
    logic [2:0]    sel;
    logic [11:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] busy, done, crd, cwr;
  logic [1:0][11:0] caddr_rd, caddr_wr;
  logic [1:0][DW-1:0] cdata_rd, cdata_wr;
  logic [1:0][2:0] csel;

  logic [DW-1:0] l0 [2][4096];
  logic [DW-1:0] l1_cap [2][2][1024];
  logic [DW-1:0] l2_cap [2][2048];
  wr_t exp_q0[$], exp_q1[$];
  wr_t we_a, we_e;
  int nchk = 0, nfail = 0;
  int cyc = 0, t0 = 0;
  int wr_cnt [2];
  int done_cnt, done_cyc, busy_cnt, first_wr_cyc, first_l2_cyc, last_l2_addr;
  bit active = 0;
  bit ok;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool_flatten #(.DW(DW), .RELU_EN(1)) u_relu (
    .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
    .crd(crd[0]), .caddr_rd(caddr_rd[0]), .cdata_rd(cdata_rd[0]), .cwr(cwr[0]),
    .caddr_wr(caddr_wr[0]), .cdata_wr(cdata_wr[0]), .csel(csel[0]));
  maxpool_flatten #(.DW(DW), .RELU_EN(0)) u_norelu (
    .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
    .crd(crd[1]), .caddr_rd(caddr_rd[1]), .cdata_rd(cdata_rd[1]), .cwr(cwr[1]),
    .caddr_wr(caddr_wr[1]), .cdata_wr(cdata_wr[1]), .csel(csel[1]));

  // L0 memory, one-cycle read latency per instance
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (crd[d]) cdata_rd[d] <= l0[int'(csel[d] == 3'b010)][caddr_rd[d]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pool(int ch, int py, int px, bit relu);
    logic signed [DW-1:0] m, v;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      v = l0[ch][(2*py + k/2)*64 + 2*px + k%2];
      if (relu && v < 0) v = '0;
      if (k == 0 || v > m) m = v;
    end
    return m;
  endfunction

  task automatic build_model();
    wr_t a, b;
    exp_q0.delete();
    exp_q1.delete();
    for (int ch = 0; ch < 2; ch++)
      for (int py = 0; py < 32; py++)
        for (int px = 0; px < 32; px++)
          for (int d = 0; d < 2; d++) begin
            a.sel = (ch == 1) ? 3'd4 : 3'd3;
            a.addr = 12'(py*32 + px);
            a.data = pool(ch, py, px, d == 0);
            b.sel = 3'd5;
            b.addr = 12'(py*64 + px*2 + ch);
            b.data = a.data;
            if (d == 0) begin exp_q0.push_back(a); exp_q0.push_back(b); end
            else begin exp_q1.push_back(a); exp_q1.push_back(b); end
          end
  endtask

  task automatic fill_random();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4096; i++) l0[c][i] = DW'($urandom);
  endtask

  task automatic clear_stats();
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    first_wr_cyc = -1; first_l2_cyc = -1; last_l2_addr = -1;
  endtask

  // Compare process: bus rules every cycle, every write against the model.
  always @(negedge clk) if (reset && active) begin
    for (int d = 0; d < 2; d++) begin
      chk("bus_rules", {62'd0, crd[d] & cwr[d], ~crd[d] & ~cwr[d] & (csel[d] != 3'd0)}, 64'd0);
      if (cwr[d]) begin
        we_a = {csel[d], caddr_wr[d], cdata_wr[d]};
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0))
          chk("wr_unexpected", 64'(we_a), 64'd0);
        else begin
          if (d == 0) we_e = exp_q0.pop_front();
          else we_e = exp_q1.pop_front();
          chk("wr_seq", 64'(we_a), 64'(we_e));
        end
        if (csel[d] == 3'd3 || csel[d] == 3'd4)
          l1_cap[d][int'(csel[d] == 3'd4)][caddr_wr[d][9:0]] = cdata_wr[d];
        if (csel[d] == 3'd5) begin
          l2_cap[d][caddr_wr[d][10:0]] = cdata_wr[d];
          if (d == 0) begin
            last_l2_addr = int'(caddr_wr[d]);
            if (first_l2_cyc < 0) first_l2_cyc = cyc;
          end
        end
        if (d == 0 && first_wr_cyc < 0) first_wr_cyc = cyc;
        wr_cnt[d]++;
      end
    end
    if (busy[0]) busy_cnt++;
    if (done[0]) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic start_run();
    @(negedge clk);
    t0 = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int repulse_at, output bit got);
    got = 0;
    for (int i = 0; i < 15000 && !got; i++) begin
      @(negedge clk);
      start = (cyc == t0 + repulse_at);
      if (done[0]) got = 1;
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_checks();
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("done_cycle", 64'(done_cyc), 64'(t0 + 14337));
    chk("busy_cycles", 64'(busy_cnt), 64'd14337);
    chk("wr_count_relu", 64'(wr_cnt[0]), 64'd4096);
    chk("wr_count_norelu", 64'(wr_cnt[1]), 64'd4096);
    chk("model_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    chk("first_l1_cycle", 64'(first_wr_cyc), 64'(t0 + 6));
    chk("first_l2_cycle", 64'(first_l2_cyc), 64'(t0 + 7));
    chk("last_l2_addr", 64'(last_l2_addr), 64'd2047);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_flags", {60'd0, busy[d], done[d], crd[d], cwr[d]}, 64'd0);
      chk("rst_csel", 64'(csel[d]), 64'd0);
      chk("rst_addr", {40'd0, caddr_rd[d], caddr_wr[d]}, 64'd0);
      chk("rst_wdata", 64'(cdata_wr[d]), 64'd0);
    end
  endtask

  initial begin
    // ---- run 1: directed windows on a random background ----
    fill_random();
    l0[0][0*64+0] = 20'h01000; l0[0][0*64+1] = 20'h03000;
    l0[0][1*64+0] = 20'h02000; l0[0][1*64+1] = 20'h00800;
    l0[0][2*64+0] = 20'hF8000; l0[0][2*64+1] = 20'hFF000;
    l0[0][3*64+0] = 20'hF0000; l0[0][3*64+1] = 20'hFC000;
    l0[1][0*64+2] = 20'h01234; l0[1][0*64+3] = 20'h0ABCD;
    l0[1][1*64+2] = 20'hFFFFF; l0[1][1*64+3] = 20'h0ABCC;
    chk("model_window", 64'(pool(0, 0, 0, 1)), 64'h03000);
    chk("model_relu_on", 64'(pool(0, 1, 0, 1)), 64'h00000);
    chk("model_relu_off", 64'(pool(0, 1, 0, 0)), 64'hFF000);
    chk("model_ch1", 64'(pool(1, 0, 1, 1)), 64'h0ABCD);

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b1;
    @(negedge clk);

    build_model();
    clear_stats();
    active = 1;
    start_run();
    chk("idle_at_t0", {62'd0, busy[0], crd[0]}, 64'd0);
    @(negedge clk);
    chk("first_rd", {busy[0], crd[0], csel[0], caddr_rd[0]}, {1'b1, 1'b1, 3'd1, 12'd0});
    wait_done(100, ok);
    run_checks();
    chk("win_l1", 64'(l1_cap[0][0][0]), 64'h03000);
    chk("win_l2", 64'(l2_cap[0][0]), 64'h03000);
    chk("relu_on_l1", 64'(l1_cap[0][0][32]), 64'h00000);
    chk("relu_on_l2", 64'(l2_cap[0][64]), 64'h00000);
    chk("relu_off_l1", 64'(l1_cap[1][0][32]), 64'hFF000);
    chk("relu_off_l2", 64'(l2_cap[1][64]), 64'hFF000);
    chk("ilv_l1", 64'(l1_cap[0][1][1]), 64'h0ABCD);
    chk("ilv_l2", 64'(l2_cap[0][3]), 64'h0ABCD);

    // ---- run 2: asynchronous reset mid-run ----
    fill_random();
    build_model();
    clear_stats();
    start_run();
    for (int i = 0; i < 6000 && cyc < t0 + 5000; i++) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'd3);
    active = 0;
    #2 reset = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    chk("no_done_aborted", 64'(done_cnt), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // ---- run 3: clean full run after reset ----
    fill_random();
    build_model();
    clear_stats();
    active = 1;
    start_run();
    wait_done(-1000, ok);
    run_checks();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/maxpool_flatten.md
Name: maxpool_flatten

Overview:
- Layer-1/Layer-2 stage directly downstream of the layer-0 convolution engine.
- Reads the two 64x64 layer-0 feature maps (L0_MEM0, L0_MEM1) over the shared memory port.
- Performs ReLU followed by 2x2 stride-2 max-pooling, writing the 32x32 results to L1_MEM0/L1_MEM1.
- Simultaneously writes the channel-interleaved flattened vector to L2_MEM.
- Started by the top controller after layer 0 completes; hands back the memory bus on done.

Parameters:
- DW, 20, data width (fixed-point, 4 integer / 16 fraction bits).
- RELU_EN, 1, 1 = clamp negative inputs to 0 before the max; 0 = pure signed max.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  one-cycle request from the top controller; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last L2 write.
- crd  out  1  memory read strobe.
- caddr_rd  out  12  read address, {row[5:0], col[5:0]}.
- cdata_rd  in  DW  read data; valid on the posedge after crd/caddr_rd/csel are presented (1-cycle latency).
- cwr  out  1  memory write strobe.
- caddr_wr  out  12  write address.
- cdata_wr  out  DW  write data.
- csel  out  3  memory select: 000 none, 001 L0_MEM0, 010 L0_MEM1, 011 L1_MEM0, 100 L1_MEM1, 101 L2_MEM.

Behaviour:
- Reset values: busy=0, done=0, crd=0, cwr=0, csel=000, caddr_rd=0, caddr_wr=0, cdata_wr=0. Internal counters cleared; state IDLE.
- Reset asserted mid-run aborts immediately to IDLE. No partial write completes after reset is asserted.
- Counters: ch (1b), py (5b), px (5b), k (2b, window index).
- Loop order: ch outer (0 then 1), py, then px (raster).
- FSM states and transitions:
  - IDLE: start=1 -> RD, busy<=1. Otherwise stay.
  - RD (4 cycles, k=0..3): crd=1, csel=001+ch, caddr_rd={2py+k[1], 2px+k[0]}. k increments each cycle; after k=3 -> LAST.
  - LAST (1 cycle): crd=0, csel=000; captures the 4th sample.
  - WR1: cwr=1, csel=011+ch, caddr_wr={2'b0, py, px}, cdata_wr=max -> WR2.
  - WR2: cwr=1, csel=101, caddr_wr={1'b0, py, px, ch}, cdata_wr=max.
    - If ch=1, py=31 and px=31 -> DONE.
    - Otherwise advance px/py/ch with wrap (px 31->0 increments py; py 31->0 increments ch) -> RD, k=0.
  - DONE: done=1 for one cycle, busy<=0 -> IDLE.
- Data capture: the sample presented in cycle RD[k] is captured in RD[k+1] (k<3) or in LAST (k=3).
- Max datapath:
  - Sample v' = (RELU_EN && v[DW-1]) ? 0 : v.
  - First sample loads max; later samples use a signed DW-bit compare, max <= (v' > max) ? v' : max.
  - No rounding, no width growth.
- Timing: 7 cycles per output pixel. Start accepted at edge t0 -> first RD at t0+1; done pulse at t0+1+14336; busy high for 14337 cycles (14336 + DONE).
- Bus rules: crd and cwr are never high together; csel is 000 whenever both are low; outputs are registered.
- start while busy is ignored.
- L1 upper address bits and L2 address bit 11 are always 0.

Decomposition:
- Package conv_pkg:
  - csel codes (CSEL_NONE, CSEL_L0_M0, CSEL_L0_M1, CSEL_L1_M0, CSEL_L1_M1, CSEL_L2).
  - DW.
  - FSM state encoding (IDLE, RD, LAST, WR1, WR2, DONE).
- One sub-module: maxpool_addr_gen. Holds the ch/py/px/k counters, the wrap logic and the last-pixel flag, and produces caddr_rd, the L1 address and the L2 address.

Test Plan:
- Window test: L0_MEM0 rows 0-1, cols 0-1 = 0x01000, 0x03000, 0x02000, 0x00800 -> L1_MEM0[0]=0x03000 and L2_MEM[0]=0x03000, written in the 6th/7th cycle after start.
- ReLU test: window all negative (0xF8000, 0xFF000, 0xF0000, 0xFC000) with RELU_EN=1 -> output 0x00000. With RELU_EN=0 -> 0xFF000.
- Interleave test: L0_MEM1 window at py=0, px=1 (rows 0-1, cols 2-3) max 0x0ABCD -> L1_MEM1[1]=0x0ABCD, L2_MEM[3]=0x0ABCD. L2 address for (py=31, px=31, ch=1) = 2047.
- Full-run test: random 64x64 maps, compared against a golden model.
  - All 2048 L1 and 2048 L2 writes match.
  - done exactly 14337 cycles after start (edge t0+1+14336).
  - crd and cwr never high together.
- Handshake test: start re-pulsed at cycle 100 of the run -> no restart, the write sequence is unchanged, a single done pulse.
- Reset test: reset driven low at cycle 5000 -> all outputs return to reset values asynchronously. A fresh start completes a clean full run.
